// File: rtl/ccip_rx_poller_pkg.sv
// Shared NIC definitions: the CCI-P channel-0 subset used by the RX poller, the RPC
// record, the position of the ring phase bit and the poller FSM state encoding.
package nic_defs;

    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3} t_ccip_clLen;
    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [63:0] arg;
        logic [31:0] fn_id;
        logic [31:0] request_id;
    } RpcIf;

    localparam int PHASE_BIT = 511;

    typedef enum logic [1:0] {PollIdle = 2'd0, PollIssue = 2'd1, PollWait = 2'd2, PollOut = 2'd3} PollState;

endpackage

// File: rtl/ccip_rx_poller_rx_ring_state.sv
// Per-flow ring bookkeeping: consumer slot pointer and the phase value expected in that slot.
module rx_ring_state #(
    parameter int LFLOWS = 1,
    parameter int LRING  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFLOWS-1:0] rd_flow,
    output logic [LRING-1:0]  rd_slot,
    output logic              rd_phase,
    input  logic              upd_en,
    input  logic [LFLOWS-1:0] upd_flow
);
    localparam int NFLOWS = 1 << LFLOWS;

    logic [NFLOWS-1:0][LRING-1:0] slot_r;
    logic [NFLOWS-1:0]            phase_r;

    // Consuming a slot advances the pointer; leaving the last slot flips the expected phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r  <= '0;
            phase_r <= '1;
        end else if (upd_en) begin
            slot_r[upd_flow] <= slot_r[upd_flow] + LRING'(1);
            if (&slot_r[upd_flow]) begin
                phase_r[upd_flow] <= ~phase_r[upd_flow];
            end
        end
    end

    assign rd_slot  = slot_r[rd_flow];
    assign rd_phase = phase_r[rd_flow];

endmodule

// File: rtl/ccip_rx_poller.sv
// Polls per-flow RX rings in host memory over CCI-P c0, one outstanding read at a time,
// and hands each freshly written line (phase bit matches) downstream as an RPC.
module ccip_rx_poller
    import nic_defs::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LRX_RING          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 rx_base_addr,
    input  logic                         start,
    input  logic                         sRx_c0TxAlmFull,
    output t_if_ccip_c0_Tx               sTx_c0,
    input  t_if_ccip_c0_Rx               sRx_c0,
    output RpcIf                         rpc_out,
    output logic                         rpc_out_valid,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    input  logic                         rpc_out_ready,
    output logic                         error,
    output logic [31:0]                  rx_rpc_cnt_out
);
    PollState                     state_r, state_s;
    logic [LMAX_NUM_OF_FLOWS-1:0] flow_r;
    logic [LRX_RING-1:0]          ring_slot_s;
    logic                         ring_phase_s;
    t_ccip_c0_ReqMemHdr           req_hdr_s;
    logic                         rsp_read_s, rsp_match_s, phase_hit_s;
    logic                         issue_s, take_s, miss_s, bad_s, done_s;
    logic                         unused_ok;

    rx_ring_state #(
        .LFLOWS (LMAX_NUM_OF_FLOWS),
        .LRING  (LRX_RING)
    ) u_ring_state (
        .clk      (clk),
        .reset    (reset),
        .rd_flow  (flow_r),
        .rd_slot  (ring_slot_s),
        .rd_phase (ring_phase_s),
        .upd_en   (done_s),
        .upd_flow (flow_r)
    );

    // Read request for the current flow's slot; mdata tags it with {flow, slot}.
    always_comb begin
        req_hdr_s          = '0;
        req_hdr_s.vc_sel   = eVC_VH0;
        req_hdr_s.cl_len   = eCL_LEN_1;
        req_hdr_s.req_type = eREQ_RDLINE_I;
        req_hdr_s.address  = rx_base_addr + (t_ccip_clAddr'(flow_r) << LRX_RING)
                           + t_ccip_clAddr'(ring_slot_s);
        req_hdr_s.mdata    = t_ccip_mdata'({flow_r, ring_slot_s});
    end

    assign rsp_read_s  = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
    assign rsp_match_s = rsp_read_s && (sRx_c0.hdr.mdata == req_hdr_s.mdata);
    assign phase_hit_s = (sRx_c0.data[PHASE_BIT] == ring_phase_s);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= PollIdle;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and single-cycle action strobes.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        take_s  = 1'b0;
        miss_s  = 1'b0;
        bad_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            PollIdle: begin
                if (start) state_s = PollIssue;
                else       state_s = PollIdle;
            end
            PollIssue: begin
                if (!sRx_c0TxAlmFull) begin
                    issue_s = 1'b1;
                    state_s = PollWait;
                end else begin
                    state_s = PollIssue;
                end
            end
            PollWait: begin
                if (rsp_match_s) begin
                    if (phase_hit_s) begin
                        take_s  = 1'b1;
                        state_s = PollOut;
                    end else begin
                        miss_s  = 1'b1;
                        state_s = PollIdle;
                    end
                end else if (rsp_read_s) begin
                    bad_s = 1'b1;
                end else begin
                    state_s = PollWait;
                end
            end
            PollOut: begin
                if (rpc_out_ready) begin
                    done_s  = 1'b1;
                    state_s = PollIdle;
                end else begin
                    state_s = PollOut;
                end
            end
            default: state_s = PollIdle;
        endcase
    end

    // A stale line moves polling on to the next flow; a shrunk flow count restarts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flow_r <= '0;
        end else if (miss_s) begin
            flow_r <= (flow_r >= number_of_flows) ? '0 : flow_r + LMAX_NUM_OF_FLOWS'(1);
        end
    end

    // Request channel; header is held between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sTx_c0 <= '0;
        end else begin
            sTx_c0.valid <= issue_s;
            if (issue_s) begin
                sTx_c0.hdr <= req_hdr_s;
            end
        end
    end

    // RPC output register, accepted-RPC counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpc_out         <= '0;
            rpc_out_valid   <= 1'b0;
            rpc_flow_id_out <= '0;
            rx_rpc_cnt_out  <= 32'd0;
            error           <= 1'b0;
        end else begin
            if (take_s) begin
                rpc_out         <= RpcIf'(sRx_c0.data[$bits(RpcIf)-1:0]);
                rpc_flow_id_out <= flow_r;
                rpc_out_valid   <= 1'b1;
            end else if (done_s) begin
                rpc_out_valid  <= 1'b0;
                rx_rpc_cnt_out <= rx_rpc_cnt_out + 32'd1;
            end
            if (bad_s) begin
                error <= 1'b1;
            end
        end
    end

    assign unused_ok = ^{NIC_ID[0], sRx_c0};

endmodule

// File: tb/tb_ccip_rx_poller.sv
// Self-checking bench for ccip_rx_poller: the bench plays the host memory and the
// downstream consumer, predicting every request and RPC from a ring-level model.
module tb_ccip_rx_poller;
    import nic_defs::*;

    localparam int LF     = 2;
    localparam int LR     = 2;
    localparam int NSLOT  = 1 << LR;
    localparam int NFLOW  = 1 << LF;
    localparam int NLINES = NFLOW * NSLOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [LF-1:0]  number_of_flows;
    t_ccip_clAddr   rx_base_addr;
    logic           start;
    logic           sRx_c0TxAlmFull;
    t_if_ccip_c0_Tx sTx_c0;
    t_if_ccip_c0_Rx sRx_c0;
    RpcIf           rpc_out;
    logic           rpc_out_valid;
    logic [LF-1:0]  rpc_flow_id_out;
    logic           rpc_out_ready;
    logic           error;
    logic [31:0]    rx_rpc_cnt_out;

    ccip_rx_poller #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LRX_RING(LR)) dut (
        .clk             (clk),
        .reset           (reset),
        .number_of_flows (number_of_flows),
        .rx_base_addr    (rx_base_addr),
        .start           (start),
        .sRx_c0TxAlmFull (sRx_c0TxAlmFull),
        .sTx_c0          (sTx_c0),
        .sRx_c0          (sRx_c0),
        .rpc_out         (rpc_out),
        .rpc_out_valid   (rpc_out_valid),
        .rpc_flow_id_out (rpc_flow_id_out),
        .rpc_out_ready   (rpc_out_ready),
        .error           (error),
        .rx_rpc_cnt_out  (rx_rpc_cnt_out)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: ring consumer position per flow, host memory contents.
    int   m_flow;
    int   m_slot [NFLOW];
    bit   m_phase[NFLOW];
    int   m_cnt;
    bit   m_err;
    int   nof;
    bit   line_phase[NLINES];
    RpcIf line_pay  [NLINES];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic RpcIf rand_pay();
        return RpcIf'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic t_ccip_c0_ReqMemHdr exp_hdr(input int f, input int s);
        t_ccip_c0_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VH0;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_RDLINE_I;
        h.address  = rx_base_addr + t_ccip_clAddr'(f * NSLOT + s);
        h.mdata    = t_ccip_mdata'(f * NSLOT + s);
        return h;
    endfunction

    task automatic model_reset();
        m_flow = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < NFLOW; i++) begin
            m_slot[i]  = 0;
            m_phase[i] = 1'b1;
        end
    endtask

    task automatic fill_lines(input bit ph);
        for (int i = 0; i < NLINES; i++) begin
            line_phase[i] = ph;
            line_pay[i]   = rand_pay();
        end
    endtask

    task automatic set_nof(input int v);
        nof             = v;
        number_of_flows = LF'(v);
    endtask

    task automatic reset_dut();
        reset           = 1'b1;
        start           = 1'b0;
        sRx_c0TxAlmFull = 1'b0;
        rpc_out_ready   = 1'b0;
        sRx_c0          = '0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Present one read response for a single cycle.
    task automatic drive_rsp(input int md, input bit ph, input RpcIf pay);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
        d[$bits(RpcIf)-1:0] = pay;
        d[PHASE_BIT]        = ph;
        sRx_c0                = '0;
        sRx_c0.rspValid       = 1'b1;
        sRx_c0.hdr.resp_type  = eRSP_RDLINE;
        sRx_c0.hdr.mdata      = t_ccip_mdata'(md);
        sRx_c0.data           = d;
        tick();
        sRx_c0 = '0;
    endtask

    // Serve one poll as the host, then consume or skip the line as the model predicts.
    task automatic do_poll(input int lat, input int rdy_wait, input bit bad, input bit stray,
                           input bit stop, output t_ccip_clAddr addr_seen);
        int n = 0;
        int f, s, idx;
        bit hit;
        addr_seen = '0;
        while (sTx_c0.valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sTx_c0.valid !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: valid=%b required 1", sTx_c0.valid);
            return;
        end
        if (stop) start = 1'b0;
        f   = m_flow;
        s   = m_slot[f];
        idx = f * NSLOT + s;
        addr_seen = sTx_c0.hdr.address;
        checks++;
        if (sTx_c0.hdr !== exp_hdr(f, s)) begin
            fails++;
            $display("FAIL req_hdr: got %h required %h", sTx_c0.hdr, exp_hdr(f, s));
        end
        tick();
        checks++;
        if (sTx_c0.valid !== 1'b0) begin
            fails++;
            $display("FAIL req_one_cycle: valid=%b required 0", sTx_c0.valid);
        end
        if (bad) begin
            drive_rsp(idx ^ 1, m_phase[f], rand_pay());
            m_err = 1'b1;
            checks++;
            if (error !== 1'b1 || rpc_out_valid !== 1'b0) begin
                fails++;
                $display("FAIL bad_mdata: error=%b valid=%b required 1 0", error, rpc_out_valid);
            end
        end
        repeat (lat - 1) tick();
        checks++;
        if (rpc_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_valid: valid=%b required 0", rpc_out_valid);
        end
        drive_rsp(idx, line_phase[idx], line_pay[idx]);
        hit = (line_phase[idx] == m_phase[f]);
        if (hit) begin
            checks++;
            if (rpc_out_valid !== 1'b1 || rpc_out !== line_pay[idx] || rpc_flow_id_out !== LF'(f)) begin
                fails++;
                $display("FAIL rpc_capture: valid=%b rpc=%h flow=%0d required 1 %h %0d",
                         rpc_out_valid, rpc_out, rpc_flow_id_out, line_pay[idx], f);
            end
            for (int i = 0; i < rdy_wait; i++) begin
                if (stray && i == 0) drive_rsp(idx, m_phase[f], rand_pay());
                else                 tick();
                checks++;
                if (rpc_out_valid !== 1'b1 || rpc_out !== line_pay[idx] ||
                    rpc_flow_id_out !== LF'(f) || sTx_c0.valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rpc_hold: valid=%b rpc=%h flow=%0d req=%b required 1 %h %0d 0",
                             rpc_out_valid, rpc_out, rpc_flow_id_out, sTx_c0.valid, line_pay[idx], f);
                end
            end
            rpc_out_ready = 1'b1;
            tick();
            rpc_out_ready = 1'b0;
            m_cnt++;
            m_slot[f] = (s + 1) % NSLOT;
            if (s == NSLOT - 1) m_phase[f] = !m_phase[f];
            checks++;
            if (rpc_out_valid !== 1'b0 || rx_rpc_cnt_out !== 32'(m_cnt)) begin
                fails++;
                $display("FAIL handshake: valid=%b cnt=%0d required 0 %0d", rpc_out_valid, rx_rpc_cnt_out, m_cnt);
            end
        end else begin
            checks++;
            if (rpc_out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_no_output: valid=%b required 0", rpc_out_valid);
            end
            m_flow = (m_flow >= nof) ? 0 : m_flow + 1;
        end
        checks++;
        if (error !== m_err) begin
            fails++;
            $display("FAIL error_state: error=%b required %b", error, m_err);
        end
    endtask

    task automatic check_idle(input string name);
        bit seen = 1'b0;
        repeat (8) begin
            tick();
            if (sTx_c0.valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL %s: request seen while stopped, required none", name);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        reset = 1'b1;
        tick();
        checks++;
        if (sTx_c0 !== '0 || rpc_out !== '0 || rpc_out_valid !== 1'b0 ||
            rpc_flow_id_out !== '0 || error !== 1'b0 || rx_rpc_cnt_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: tx=%h rpc=%h v=%b fl=%0d err=%b cnt=%0d required all 0",
                     sTx_c0, rpc_out, rpc_out_valid, rpc_flow_id_out, error, rx_rpc_cnt_out);
        end
        reset = 1'b0;
        check_idle("idle_without_start");
    endtask

    task automatic test_single();
        t_ccip_clAddr a;
        reset_dut();
        set_nof(0);
        fill_lines(1'b0);
        line_phase[0] = 1'b1;
        start = 1'b1;
        do_poll(3, 0, 1'b0, 1'b0, 1'b0, a);
        checks++;
        if (a !== rx_base_addr || rx_rpc_cnt_out !== 32'd1) begin
            fails++;
            $display("FAIL single_rpc: addr=%h cnt=%0d required %h 1", a, rx_rpc_cnt_out, rx_base_addr);
        end
        do_poll(2, 0, 1'b0, 1'b0, 1'b1, a);
        check_idle("single_stop");
    endtask

    task automatic test_flow_cycle();
        t_ccip_clAddr a;
        int exp_off[5] = '{0, 4, 8, 12, 0};
        reset_dut();
        set_nof(3);
        fill_lines(1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_poll(1 + (i % 3), 0, 1'b0, 1'b0, i == 4, a);
            checks++;
            if (a !== rx_base_addr + t_ccip_clAddr'(exp_off[i])) begin
                fails++;
                $display("FAIL flow_cycle_addr%0d: got %h required %h", i, a, rx_base_addr + t_ccip_clAddr'(exp_off[i]));
            end
        end
        checks++;
        if (rx_rpc_cnt_out !== 32'd0) begin
            fails++;
            $display("FAIL flow_cycle_cnt: cnt=%0d required 0", rx_rpc_cnt_out);
        end
    endtask

    task automatic test_wrap();
        t_ccip_clAddr a;
        reset_dut();
        set_nof(1);
        fill_lines(1'b0);
        for (int s = 0; s < NSLOT; s++) line_phase[NSLOT + s] = 1'b1;
        start = 1'b1;
        do_poll(2, 0, 1'b0, 1'b0, 1'b0, a);
        for (int s = 0; s < NSLOT; s++) do_poll(2, (s == 1) ? 10 : 0, 1'b0, 1'b0, 1'b0, a);
        line_phase[NSLOT] = 1'b0;
        line_pay[NSLOT]   = rand_pay();
        do_poll(4, 1, 1'b0, 1'b0, 1'b0, a);
        checks++;
        if (a !== rx_base_addr + t_ccip_clAddr'(NSLOT) || rx_rpc_cnt_out !== 32'd5) begin
            fails++;
            $display("FAIL wrap_reread: addr=%h cnt=%0d required %h 5", a, rx_rpc_cnt_out,
                     rx_base_addr + t_ccip_clAddr'(NSLOT));
        end
        do_poll(1, 0, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic test_bad_mdata();
        t_ccip_clAddr a;
        reset_dut();
        set_nof(0);
        fill_lines(1'b0);
        line_phase[0] = 1'b1;
        start = 1'b1;
        do_poll(4, 1, 1'b1, 1'b0, 1'b0, a);
        do_poll(2, 0, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic test_random();
        t_ccip_clAddr a;
        reset_dut();
        rx_base_addr = t_ccip_clAddr'({$urandom(), $urandom()});
        set_nof(3);
        for (int i = 0; i < NLINES; i++) begin
            line_phase[i] = 1'($urandom_range(0, 1));
            line_pay[i]   = rand_pay();
        end
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) set_nof($urandom_range(0, 3));
            if (i % 7 == 6) line_phase[$urandom_range(0, NLINES - 1)] ^= 1'b1;
            do_poll($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, i == 39, a);
        end
        check_idle("random_stop");
    endtask

    task automatic test_almfull_reset();
        t_ccip_clAddr a;
        bit seen = 1'b0;
        int n = 0;
        reset_dut();
        set_nof(0);
        fill_lines(1'b1);
        sRx_c0TxAlmFull = 1'b1;
        start = 1'b1;
        repeat (10) begin
            tick();
            if (sTx_c0.valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL almfull_block: request issued while full, required none");
        end
        sRx_c0TxAlmFull = 1'b0;
        while (sTx_c0.valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sTx_c0.valid !== 1'b1) begin
            fails++;
            $display("FAIL almfull_release: valid=%b required 1", sTx_c0.valid);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (sTx_c0 !== '0 || rpc_out !== '0 || rpc_out_valid !== 1'b0 ||
            rpc_flow_id_out !== '0 || error !== 1'b0 || rx_rpc_cnt_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_midwait: tx=%h v=%b err=%b cnt=%0d required all 0",
                     sTx_c0, rpc_out_valid, error, rx_rpc_cnt_out);
        end
        start = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        drive_rsp(0, 1'b1, line_pay[0]);
        tick();
        checks++;
        if (rpc_out_valid !== 1'b0 || error !== 1'b0 || rx_rpc_cnt_out !== 32'd0 || sTx_c0.valid !== 1'b0) begin
            fails++;
            $display("FAIL late_rsp_ignored: v=%b err=%b cnt=%0d req=%b required 0 0 0 0",
                     rpc_out_valid, error, rx_rpc_cnt_out, sTx_c0.valid);
        end
        start = 1'b1;
        do_poll(2, 0, 1'b0, 1'b0, 1'b1, a);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        sRx_c0TxAlmFull = 1'b0;
        rpc_out_ready   = 1'b0;
        sRx_c0          = '0;
        rx_base_addr    = 42'h0_0123_4560;
        set_nof(0);
        model_reset();
        test_reset();
        test_single();
        test_flow_cycle();
        test_wrap();
        test_bad_mdata();
        test_random();
        test_almfull_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ccip_rx_poller.md
CCIP_RX_POLLER -- requirements
Module: ccip_rx_poller

Interface
REQ-001 SHALL have parameter NIC_ID, default 0; NIC index used in simulation messages only.
REQ-002 SHALL have parameter LMAX_NUM_OF_FLOWS, default 1; log2 of the maximum number of flows.
REQ-003 SHALL have parameter LRX_RING, default 2; log2 of the ring depth, in cache lines, per flow.
REQ-004 SHALL have port clk, input, 1 bit; the only clock.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-006 SHALL have port number_of_flows, input, LMAX_NUM_OF_FLOWS bits; index of the highest active flow.
REQ-007 SHALL have port rx_base_addr, input, t_ccip_clAddr; host address of flow 0, slot 0.
REQ-008 SHALL have port start, input, 1 bit; enables issue of new polls.
REQ-009 SHALL have port sRx_c0TxAlmFull, input, 1 bit; c0 request backpressure.
REQ-010 SHALL have port sTx_c0, output, t_if_ccip_c0_Tx; read requests.
REQ-011 SHALL have port sRx_c0, input, t_if_ccip_c0_Rx; read responses.
REQ-012 SHALL have port rpc_out, output, RpcIf; received RPC.
REQ-013 SHALL have port rpc_out_valid, output, 1 bit; rpc_out holds a valid RPC.
REQ-014 SHALL have port rpc_flow_id_out, output, LMAX_NUM_OF_FLOWS bits; source flow of rpc_out.
REQ-015 SHALL have port rpc_out_ready, input, 1 bit; downstream accepts the RPC.
REQ-016 SHALL have port error, output, 1 bit; sticky protocol error.
REQ-017 SHALL have port rx_rpc_cnt_out, output, 32 bits; count of accepted RPCs.

Function
REQ-018 SHALL keep one ring per flow; line address = rx_base_addr + (flow << LRX_RING) + slot.
REQ-019 SHALL keep per flow a slot pointer (LRX_RING bits) and an expected phase bit (reset value 1).
REQ-020 SHALL use FSM states PollIdle, PollIssue, PollWait and PollOut.
REQ-021 PollIdle: when start=1, go to PollIssue for the current flow.
REQ-022 PollIssue: when sRx_c0TxAlmFull=0, drive sTx_c0.valid=1 for exactly one cycle.
REQ-023 The PollIssue request SHALL use eREQ_RDLINE_I, eVC_VH0, cl_len eCL_LEN_1, and mdata = {flow, slot} zero-extended; then go to PollWait.
REQ-024 PollWait: accept an sRx_c0 response whose resp_type is eRSP_RDLINE and whose mdata matches.
REQ-025 A mismatched-mdata read response in PollWait SHALL set error; the FSM stays in PollWait.
REQ-026 In PollWait, if data[511] equals the expected phase, register rpc_out = data[$bits(RpcIf)-1:0] and the flow id, set rpc_out_valid on the next cycle, and go to PollOut.
REQ-027 In PollWait, if data[511] does not equal the expected phase, advance to the next flow and go to PollIdle.
REQ-028 PollOut: hold rpc_out, rpc_out_valid and rpc_flow_id_out stable until rpc_out_ready=1.
REQ-029 On the PollOut handshake: deassert valid next cycle, increment slot and rx_rpc_cnt_out, stay on the same flow, and go to PollIdle.
REQ-030 Slot wrap from 2^LRX_RING-1 to 0 SHALL toggle that flow's expected phase.
REQ-031 Flow advance SHALL wrap from number_of_flows to 0.
REQ-032 A runtime change of number_of_flows below the current flow SHALL force the next advance to 0.
REQ-033 At most one read SHALL be outstanding.
REQ-034 Responses arriving outside PollWait SHALL be ignored; error is unaffected.
REQ-035 start deasserted mid-transaction SHALL let the current poll and output complete; no new request is issued.
REQ-036 rx_rpc_cnt_out SHALL wrap modulo 2^32.
REQ-037 Request-to-output latency SHALL be the host read latency + 1 cycle.

Reset
REQ-038 Reset SHALL asynchronously force PollIdle, flow 0, all slots 0, all phases 1, and rx_rpc_cnt_out=0.
REQ-039 Reset SHALL asynchronously force sTx_c0.valid=0, rpc_out_valid=0 and error=0.
REQ-040 Reset SHALL asynchronously force rpc_out=0, rpc_flow_id_out=0 and sTx_c0.hdr=0.
REQ-041 A response in flight across reset SHALL be discarded per REQ-034.

Structure
REQ-042 RpcIf, the phase-bit position (511) and the PollState enum SHALL live in the shared NIC package with nic_defs.
REQ-043 Per-flow slot/phase storage SHALL be a sub-module, rx_ring_state, with read/update-by-flow-id ports.

Verification
REQ-044 Reset, then start=1, 1 flow, line0 data[511]=1 -> one RDLINE to base+0, rpc_out_valid with flow 0, count=1.
REQ-045 number_of_flows=3 with all lines phase 0 -> reads cycle base+0, +4, +8, +12, base+0 (LRX_RING=2), with no output.
REQ-046 Flow 1 fills 4 slots with phase 1, then slot 0 with phase 0 -> 5 RPCs, slot 0 is re-read after wrap, and the phase expected there is 0.
REQ-047 Hold rpc_out_ready=0 for 10 cycles -> output stays stable and no new sTx_c0.valid occurs.
REQ-048 Inject a response with wrong mdata -> error=1 sticky, and the correct response still completes.
REQ-049 sRx_c0TxAlmFull=1 then reset asserted mid-PollWait -> no request while full, all outputs zero, and the late response is ignored.
